// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises word/half/byte fetch, load and store requests into
// one-byte-per-cycle accesses on a byte-wide RAM/IO bus.
// Arbitration is store > load > fetch, and load results are extended to 32 bits.
// Optional macro MEM_CTRL_ICACHE_EN adds a direct-mapped one-word-per-line
// instruction cache in front of the fetch path.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE      = 32'h00030000,
  parameter int          ICACHE_LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_rob_xbp,
  input  logic        in_if_flag,
  input  logic [31:0] in_if_addr,
  output logic        out_if_done,
  output logic [31:0] out_if_data,
  input  logic        in_lsb_flag,
  input  logic [5:0]  in_lsb_size,
  input  logic        in_lsb_signed,
  input  logic [31:0] in_lsb_addr,
  output logic        out_lsb_done,
  output logic [31:0] out_lsb_data,
  input  logic        in_rob_st_flag,
  input  logic [5:0]  in_rob_st_size,
  input  logic [31:0] in_rob_st_addr,
  input  logic [31:0] in_rob_st_data,
  output logic        out_rob_st_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d, n_q, n_d;
  logic [31:0] base_q, base_d, buf_q, buf_d;
  logic        sgn_q, sgn_d;
  logic        pend_if_q, pend_if_d, pend_lsb_q, pend_lsb_d, pend_st_q, pend_st_d;
  logic [31:0] if_addr_q, if_addr_d, lsb_addr_q, lsb_addr_d, st_addr_q, st_addr_d;
  logic [2:0]  lsb_n_q, lsb_n_d, st_n_q, st_n_d;
  logic        lsb_sgn_q, lsb_sgn_d;
  logic [31:0] st_data_q, st_data_d;
  logic        if_done_q, if_done_d, lsb_done_q, lsb_done_d, st_done_q, st_done_d;
  logic [31:0] if_data_q, if_data_d, lsb_data_q, lsb_data_d;

  logic        flush, io_blk;
  logic        eff_if, eff_lsb, eff_st;
  logic [31:0] eff_if_addr, rd_word;
  logic        if_hit;
  logic [31:0] hit_data;

  // Anything other than 1 or 2 bytes is handled as a full word.
  function automatic logic [2:0] size_to_n(input logic [5:0] s);
    case (s)
      6'd1:    return 3'd1;
      6'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n, input logic s);
    case (n)
      3'd1:    return {{24{s & w[7]}}, w[7:0]};
      3'd2:    return {{16{s & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign flush       = rdy & in_rob_xbp;
  assign io_blk      = (base_q >= IO_BASE) & io_buffer_full;
  // A request pulsed this cycle is visible to the arbiter immediately.
  assign eff_if      = ~flush & (pend_if_q | in_if_flag);
  assign eff_lsb     = ~flush & (pend_lsb_q | in_lsb_flag);
  assign eff_st      = pend_st_q | in_rob_st_flag;
  assign eff_if_addr = pend_if_q ? if_addr_q : in_if_addr;

`ifdef MEM_CTRL_ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] ic_valid_q;
  logic [TAG_W-1:0]        ic_tag_q [ICACHE_LINES];
  logic [31:0]             ic_data_q [ICACHE_LINES];
  logic [IDX_W-1:0]        hit_idx, fill_idx, inv_idx0, inv_idx1;
  logic [31:0]             inv_end;
  logic                    ic_fill, st_fin;

  assign hit_idx  = eff_if_addr[IDX_W+1:2];
  // The fetch currently being filled from RAM is never also served as a hit.
  assign if_hit   = eff_if && (state_q != S_FETCH) && ic_valid_q[hit_idx] &&
                    (ic_tag_q[hit_idx] == eff_if_addr[31:IDX_W+2]);
  assign hit_data = ic_data_q[hit_idx];
  assign fill_idx = base_q[IDX_W+1:2];
  assign inv_end  = base_q + {29'd0, n_q} - 32'd1;
  assign inv_idx0 = base_q[IDX_W+1:2];
  assign inv_idx1 = inv_end[IDX_W+1:2];
  assign ic_fill  = (state_q == S_FETCH) && (k_q == n_q) && !flush;
  assign st_fin   = (state_q == S_STORE) && !io_blk && (k_q == n_q - 3'd1);

  // Valid bits: set on fill, cleared by any finished store touching the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_valid_q <= '0;
    end else if (rdy) begin
      if (ic_fill) ic_valid_q[fill_idx] <= 1'b1;
      if (st_fin) begin
        if (ic_tag_q[inv_idx0] == base_q[31:IDX_W+2])  ic_valid_q[inv_idx0] <= 1'b0;
        if (ic_tag_q[inv_idx1] == inv_end[31:IDX_W+2]) ic_valid_q[inv_idx1] <= 1'b0;
      end
    end
  end

  // Tag/data storage written when a missed fetch completes.
  always_ff @(posedge clk) begin
    if (rdy && ic_fill) begin
      ic_tag_q[fill_idx]  <= base_q[31:IDX_W+2];
      ic_data_q[fill_idx] <= rd_word;
    end
  end
`else
  assign if_hit   = 1'b0;
  assign hit_data = 32'd0;
`endif

  // Read assembly: the byte requested last cycle lands in lane k-1.
  always_comb begin
    rd_word = buf_q;
    case (k_q)
      3'd1:    rd_word[7:0]   = mem_din;
      3'd2:    rd_word[15:8]  = mem_din;
      3'd3:    rd_word[23:16] = mem_din;
      3'd4:    rd_word[31:24] = mem_din;
      default: rd_word = buf_q;
    endcase
  end

  // Request latching, arbitration and byte sequencing.
  always_comb begin
    state_d = state_q;  k_d = k_q;  n_d = n_q;  base_d = base_q;  buf_d = buf_q;  sgn_d = sgn_q;
    pend_if_d = pend_if_q;  if_addr_d = if_addr_q;
    pend_lsb_d = pend_lsb_q;  lsb_addr_d = lsb_addr_q;  lsb_n_d = lsb_n_q;  lsb_sgn_d = lsb_sgn_q;
    pend_st_d = pend_st_q;  st_addr_d = st_addr_q;  st_n_d = st_n_q;  st_data_d = st_data_q;
    if_done_d = 1'b0;  lsb_done_d = 1'b0;  st_done_d = 1'b0;
    if_data_d = if_data_q;  lsb_data_d = lsb_data_q;

    if (!pend_if_q && in_if_flag) begin
      pend_if_d = 1'b1;  if_addr_d = in_if_addr;
    end
    if (!pend_lsb_q && in_lsb_flag) begin
      pend_lsb_d = 1'b1;  lsb_addr_d = in_lsb_addr;
      lsb_n_d = size_to_n(in_lsb_size);  lsb_sgn_d = in_lsb_signed;
    end
    if (!pend_st_q && in_rob_st_flag) begin
      pend_st_d = 1'b1;  st_addr_d = in_rob_st_addr;
      st_n_d = size_to_n(in_rob_st_size);  st_data_d = in_rob_st_data;
    end
    if (flush) begin
      pend_if_d = 1'b0;  pend_lsb_d = 1'b0;
    end
    if (if_hit) begin
      pend_if_d = 1'b0;  if_done_d = 1'b1;  if_data_d = hit_data;
    end

    case (state_q)
      S_IDLE: begin
        k_d = 3'd0;  buf_d = 32'd0;
        if (eff_st) begin
          state_d = S_STORE;
          base_d  = pend_st_q ? st_addr_q : in_rob_st_addr;
          n_d     = pend_st_q ? st_n_q : size_to_n(in_rob_st_size);
        end else if (eff_lsb) begin
          state_d = S_LOAD;
          base_d  = pend_lsb_q ? lsb_addr_q : in_lsb_addr;
          n_d     = pend_lsb_q ? lsb_n_q : size_to_n(in_lsb_size);
          sgn_d   = pend_lsb_q ? lsb_sgn_q : in_lsb_signed;
        end else if (eff_if && !if_hit) begin
          state_d = S_FETCH;  base_d = eff_if_addr;  n_d = 3'd4;  sgn_d = 1'b0;
        end
      end
      S_FETCH, S_LOAD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (k_q != 3'd0) buf_d = rd_word;
          if (k_q == n_q) begin
            state_d = S_IDLE;
            if (state_q == S_FETCH) begin
              if_done_d = 1'b1;  if_data_d = rd_word;  pend_if_d = 1'b0;
            end else begin
              lsb_done_d = 1'b1;  lsb_data_d = extend(rd_word, n_q, sgn_q);  pend_lsb_d = 1'b0;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      S_STORE: begin
        if (!io_blk) begin
          if (k_q == n_q - 3'd1) begin
            state_d = S_IDLE;  st_done_d = 1'b1;  pend_st_d = 1'b0;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; rdy low freezes everything but still ends done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;  k_q <= '0;  n_q <= '0;  base_q <= '0;  buf_q <= '0;  sgn_q <= 1'b0;
      pend_if_q <= 1'b0;  if_addr_q <= '0;
      pend_lsb_q <= 1'b0;  lsb_addr_q <= '0;  lsb_n_q <= '0;  lsb_sgn_q <= 1'b0;
      pend_st_q <= 1'b0;  st_addr_q <= '0;  st_n_q <= '0;  st_data_q <= '0;
      if_done_q <= 1'b0;  lsb_done_q <= 1'b0;  st_done_q <= 1'b0;
      if_data_q <= '0;  lsb_data_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;  k_q <= k_d;  n_q <= n_d;  base_q <= base_d;  buf_q <= buf_d;  sgn_q <= sgn_d;
      pend_if_q <= pend_if_d;  if_addr_q <= if_addr_d;
      pend_lsb_q <= pend_lsb_d;  lsb_addr_q <= lsb_addr_d;  lsb_n_q <= lsb_n_d;  lsb_sgn_q <= lsb_sgn_d;
      pend_st_q <= pend_st_d;  st_addr_q <= st_addr_d;  st_n_q <= st_n_d;  st_data_q <= st_data_d;
      if_done_q <= if_done_d;  lsb_done_q <= lsb_done_d;  st_done_q <= st_done_d;
      if_data_q <= if_data_d;  lsb_data_q <= lsb_data_d;
    end else begin
      if_done_q <= 1'b0;  lsb_done_q <= 1'b0;  st_done_q <= 1'b0;
    end
  end

  // Bus drive follows the registered state so an async reset drops it at once.
  always_comb begin
    mem_a    = 32'd0;
    mem_wr   = 1'b0;
    mem_dout = 8'd0;
    if (state_q != S_IDLE) mem_a = base_q + {29'd0, k_q};
    if (state_q == S_STORE) begin
      mem_wr = rdy & ~io_blk;
      case (k_q)
        3'd0:    mem_dout = st_data_q[7:0];
        3'd1:    mem_dout = st_data_q[15:8];
        3'd2:    mem_dout = st_data_q[23:16];
        default: mem_dout = st_data_q[31:24];
      endcase
    end
  end

  assign out_if_done     = if_done_q;
  assign out_if_data     = if_data_q;
  assign out_lsb_done    = lsb_done_q;
  assign out_lsb_data    = lsb_data_q;
  assign out_rob_st_done = st_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected done events and bus
// writes into queues; a negedge monitor pops and compares them.
module tb_mem_ctrl;

  logic        clk, rst, rdy, in_rob_xbp;
  logic        in_if_flag;
  logic [31:0] in_if_addr;
  logic        out_if_done;
  logic [31:0] out_if_data;
  logic        in_lsb_flag;
  logic [5:0]  in_lsb_size;
  logic        in_lsb_signed;
  logic [31:0] in_lsb_addr;
  logic        out_lsb_done;
  logic [31:0] out_lsb_data;
  logic        in_rob_st_flag;
  logic [5:0]  in_rob_st_size;
  logic [31:0] in_rob_st_addr, in_rob_st_data;
  logic        out_rob_st_done;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  typedef struct { int kind; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  exp_t me;
  wr_t  mw;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] ram [0:1023];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_rob_xbp(in_rob_xbp),
    .in_if_flag(in_if_flag), .in_if_addr(in_if_addr),
    .out_if_done(out_if_done), .out_if_data(out_if_data),
    .in_lsb_flag(in_lsb_flag), .in_lsb_size(in_lsb_size), .in_lsb_signed(in_lsb_signed),
    .in_lsb_addr(in_lsb_addr), .out_lsb_done(out_lsb_done), .out_lsb_data(out_lsb_data),
    .in_rob_st_flag(in_rob_st_flag), .in_rob_st_size(in_rob_st_size),
    .in_rob_st_addr(in_rob_st_addr), .in_rob_st_data(in_rob_st_data),
    .out_rob_st_done(out_rob_st_done),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // RAM model: read data appears the cycle after the address.
  always @(posedge clk) mem_din <= ram[mem_a[9:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic check_done(input int kind, input logic [31:0] data);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_done: got done kind %0d expected none", kind);
    end else begin
      me = exp_q.pop_front();
      chk("done_kind", 32'(kind), 32'(me.kind));
      if (kind != 2) chk("done_data", data, me.data);
    end
  endtask

  // Monitor: every bus write and every done pulse is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr) begin
        if (wr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got a=%h d=%h expected none", mem_a, mem_dout);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_addr", mem_a, mw.a);
          chk("wr_data", {24'd0, mem_dout}, {24'd0, mw.d});
        end
      end
      if (out_rob_st_done) check_done(2, 32'd0);
      if (out_lsb_done)    check_done(1, out_lsb_data);
      if (out_if_done)     check_done(0, out_if_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return out_if_done;
      1:       return out_lsb_done;
      default: return out_rob_st_done;
    endcase
  endfunction

  // Counts negedges from the current cycle until the selected done shows.
  task automatic wait_sig(input int which, input int limit, output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (sig(which)) break;
      if (lat >= limit) begin
        vectors++;
        miscompares++;
        $display("FAIL done_timeout: got no done on %0d after %0d cycles expected one", which, lat);
        lat = -1;
        break;
      end
      lat++;
    end
  endtask

  task automatic do_load(input logic [5:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] expd, input int exp_lat);
    int lat;
    exp_q.push_back('{1, expd});
    in_lsb_flag = 1'b1;  in_lsb_size = sz;  in_lsb_signed = sg;  in_lsb_addr = a;
    tick();
    in_lsb_flag = 1'b0;
    wait_sig(1, 20, lat);
    chk("lsb_latency", 32'(lat), 32'(exp_lat));
    tick();
  endtask

  initial begin
    int lat;
    int saw;
    rst = 1'b1;  rdy = 1'b1;  in_rob_xbp = 1'b0;  io_buffer_full = 1'b0;
    in_if_flag = 1'b0;  in_if_addr = '0;
    in_lsb_flag = 1'b0;  in_lsb_size = '0;  in_lsb_signed = 1'b0;  in_lsb_addr = '0;
    in_rob_st_flag = 1'b0;  in_rob_st_size = '0;  in_rob_st_addr = '0;  in_rob_st_data = '0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13;  ram[10'h101] = 8'h05;  ram[10'h102] = 8'h10;  ram[10'h103] = 8'h00;
    ram[10'h020] = 8'h80;  ram[10'h021] = 8'hFF;  ram[10'h022] = 8'h12;  ram[10'h023] = 8'h34;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_if_done", {31'd0, out_if_done}, 32'd0);
    chk("rst_lsb_done", {31'd0, out_lsb_done}, 32'd0);
    chk("rst_st_done", {31'd0, out_rob_st_done}, 32'd0);
    chk("rst_if_data", out_if_data, 32'd0);
    chk("rst_lsb_data", out_lsb_data, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Fetch @0x100: done five cycles after FETCH entry
    exp_q.push_back('{0, 32'h00100513});
    in_if_flag = 1'b1;  in_if_addr = 32'h100;
    tick();
    in_if_flag = 1'b0;
    @(negedge clk);
    chk("fetch_a0", mem_a, 32'h100);
    chk("fetch_wr0", {31'd0, mem_wr}, 32'd0);
    wait_sig(0, 20, lat);
    chk("fetch_latency", 32'(lat + 1), 32'd5);
    tick();

    // Loads with sign/zero extension and an undefined size
    do_load(6'd1, 1'b1, 32'h20, 32'hFFFFFF80, 2);
    do_load(6'd1, 1'b0, 32'h20, 32'h00000080, 2);
    do_load(6'd2, 1'b0, 32'h20, 32'h0000FF80, 3);
    do_load(6'd2, 1'b1, 32'h20, 32'hFFFFFF80, 3);
    do_load(6'd4, 1'b0, 32'h20, 32'h3412FF80, 5);
    do_load(6'd3, 1'b1, 32'h20, 32'h3412FF80, 5);

    // Same-cycle store, load and fetch: served store, load, fetch
    wr_q.push_back('{32'h40, 8'h44});  wr_q.push_back('{32'h41, 8'h33});
    wr_q.push_back('{32'h42, 8'h22});  wr_q.push_back('{32'h43, 8'h11});
    exp_q.push_back('{2, 32'd0});
    exp_q.push_back('{1, 32'h3412FF80});
    exp_q.push_back('{0, 32'h00100513});
    in_rob_st_flag = 1'b1;  in_rob_st_size = 6'd4;  in_rob_st_addr = 32'h40;  in_rob_st_data = 32'h11223344;
    in_lsb_flag = 1'b1;  in_lsb_size = 6'd4;  in_lsb_signed = 1'b0;  in_lsb_addr = 32'h20;
    in_if_flag = 1'b1;  in_if_addr = 32'h100;
    tick();
    in_rob_st_flag = 1'b0;  in_lsb_flag = 1'b0;  in_if_flag = 1'b0;
    wait_sig(0, 40, lat);
    tick();

    // IO byte store held off by io_buffer_full for three cycles
    wr_q.push_back('{32'h00030000, 8'h41});
    exp_q.push_back('{2, 32'd0});
    io_buffer_full = 1'b1;
    in_rob_st_flag = 1'b1;  in_rob_st_size = 6'd1;  in_rob_st_addr = 32'h00030000;  in_rob_st_data = 32'h41;
    tick();
    in_rob_st_flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("io_blocked_wr", {31'd0, mem_wr}, 32'd0);
      tick();
    end
    io_buffer_full = 1'b0;
    @(negedge clk);
    chk("io_write_wr", {31'd0, mem_wr}, 32'd1);
    tick();
    @(negedge clk);
    chk("io_st_done", {31'd0, out_rob_st_done}, 32'd1);
    tick();

    // Flush during a word load at byte 2: no done, back to IDLE
    in_lsb_flag = 1'b1;  in_lsb_size = 6'd4;  in_lsb_addr = 32'h20;
    tick();
    in_lsb_flag = 1'b0;
    tick();
    tick();
    in_rob_xbp = 1'b1;
    tick();
    in_rob_xbp = 1'b0;
    @(negedge clk);
    chk("flush_idle_mem_a", mem_a, 32'd0);
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_lsb_done) saw++;
      tick();
      @(negedge clk);
    end
    chk("flush_no_lsb_done", 32'(saw), 32'd0);
    chk("flush_lsb_data_hold", out_lsb_data, 32'h3412FF80);
    tick();

    // A store in flight when a flush arrives still completes
    wr_q.push_back('{32'h50, 8'hEF});  wr_q.push_back('{32'h51, 8'hBE});
    exp_q.push_back('{2, 32'd0});
    in_rob_st_flag = 1'b1;  in_rob_st_size = 6'd2;  in_rob_st_addr = 32'h50;  in_rob_st_data = 32'h0000BEEF;
    tick();
    in_rob_st_flag = 1'b0;
    tick();
    in_rob_xbp = 1'b1;
    tick();
    in_rob_xbp = 1'b0;
    wait_sig(2, 10, lat);
    chk("flush_st_latency", 32'(lat), 32'd0);
    tick();

    // rdy low stalls a store and forces mem_wr low
    wr_q.push_back('{32'h70, 8'h5A});
    exp_q.push_back('{2, 32'd0});
    in_rob_st_flag = 1'b1;  in_rob_st_size = 6'd1;  in_rob_st_addr = 32'h70;  in_rob_st_data = 32'h5A;
    tick();
    in_rob_st_flag = 1'b0;
    rdy = 1'b0;
    @(negedge clk);
    chk("rdy_low_wr", {31'd0, mem_wr}, 32'd0);
    tick();
    @(negedge clk);
    chk("rdy_low_mem_a", mem_a, 32'h70);
    tick();
    rdy = 1'b1;
    wait_sig(2, 10, lat);
    chk("rdy_st_latency", 32'(lat), 32'd1);
    tick();

    // Asynchronous reset in the middle of a word store
    wr_q.push_back('{32'h60, 8'hDD});
    in_rob_st_flag = 1'b1;  in_rob_st_size = 6'd4;  in_rob_st_addr = 32'h60;  in_rob_st_data = 32'hAABBCCDD;
    tick();
    in_rob_st_flag = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("arst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("arst_mem_a", mem_a, 32'd0);
    chk("arst_dones", {29'd0, out_if_done, out_lsb_done, out_rob_st_done}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (6) tick();

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory controller between the load/store buffer, the ROB store-commit path, the instruction fetcher and the byte-wide RAM/IO bus.
- Accepts word/half/byte requests and serialises them into one-byte-per-cycle RAM accesses.
- Sign- or zero-extends load results and returns them with a one-cycle done pulse.
- Arbitrates the three requesters: store > load > fetch.

Parameters:
IO_BASE, 32'h00030000, addresses >= IO_BASE are IO space; writes there obey io_buffer_full
ICACHE_LINES, 16, number of one-word lines when MEM_CTRL_ICACHE_EN is defined (power of two)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global ready; low freezes all state
in_rob_xbp  in  1  branch mispredict flush
in_if_flag  in  1  fetch request pulse
in_if_addr  in  32  fetch address (word aligned)
out_if_done  out  1  fetch complete pulse
out_if_data  out  32  fetched instruction
in_lsb_flag  in  1  load request pulse
in_lsb_size  in  6  bytes: 1, 2 or 4
in_lsb_signed  in  1  1 = sign-extend
in_lsb_addr  in  32  load address
out_lsb_done  out  1  load complete pulse
out_lsb_data  out  32  extended load data
in_rob_st_flag  in  1  committed store request pulse
in_rob_st_size  in  6  bytes: 1, 2 or 4
in_rob_st_addr  in  32  store address
in_rob_st_data  in  32  store data (low bytes used)
out_rob_st_done  out  1  store complete pulse
mem_din  in  8  RAM read byte (valid the cycle after mem_a)
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1 = write
io_buffer_full  in  1  IO write buffer full

Behaviour:
- Reset (async, rst=1):
  - state IDLE; pending latches cleared.
  - All outputs 0: done pulses, data, mem_a, mem_dout, mem_wr.
- Request pulses set pending_{if,lsb,st} with captured address/size/data.
  - A pulse while the same pending bit is set is ignored; upstream guarantees one outstanding request per source.
- States: IDLE, FETCH, LOAD, STORE.
- IDLE:
  - Choose the highest-priority pending request (st > lsb > if), including one pulsed this cycle.
  - Load counter k=0 and N=size (fetch N=4), then enter the state.
- Read (FETCH/LOAD):
  - Cycle k drives mem_a=addr+k, mem_wr=0, for k=0..N-1.
  - mem_din is captured into byte k-1 in cycle k, for k=1..N.
  - After capturing the last byte, register the done pulse, clear pending and return to IDLE.
  - Latency from state entry to done: N+1 cycles.
  - A new request may be selected in the cycle done is high.
- Extension:
  - Size 1: signed replicates bit 7, unsigned zero-fills.
  - Size 2: signed replicates bit 15, unsigned zero-fills.
  - Size 4: passed through.
  - Fetch data is little-endian.
- STORE:
  - Cycle k drives mem_a=addr+k, mem_wr=1, mem_dout=data[8k+7:8k].
  - If addr >= IO_BASE and io_buffer_full=1: drive mem_wr=0, hold k.
  - After byte N-1: out_rob_st_done pulse next cycle, IDLE.
- Done pulses are exactly one cycle; data outputs hold until the next done.
- Flush (in_rob_xbp=1, rdy=1):
  - FETCH/LOAD abort to IDLE with no done; pending_if and pending_lsb are cleared.
  - STORE and pending_st are unaffected; committed stores always complete.
  - Same-cycle if/lsb request pulses are dropped.
- rdy=0: no state/counter change; mem_wr forced 0.
- Undefined size values (not 1/2/4) are treated as 4.
- Address wrap past 32'hFFFFFFFF is mod 2^32.

Optional Feature:
- MEM_CTRL_ICACHE_EN defined: direct-mapped instruction cache of ICACHE_LINES one-word lines.
  - Index = addr[log2(ICACHE_LINES)+1:2]; tag = remaining high bits; valid bit per line.
  - Fetch hit: out_if_done the cycle after the request is accepted, no RAM access, even while LOAD/STORE runs.
  - Miss: normal FETCH, then fill the line.
  - Any completed store overlapping a cached word invalidates that line.
  - Reset clears all valid bits; flush does not.
- Undefined: every fetch goes to RAM as described above.

Test Plan:
- Fetch @0x100, RAM[0x100..0x103]=13,05,10,00 -> out_if_done 5 cycles after FETCH entry, out_if_data=32'h00100513.
- LB signed @0x20 with RAM=0x80 -> out_lsb_data=32'hFFFFFF80; LHU @0x20 with 0x80,0xFF -> 32'h0000FF80.
- Same-cycle store SW 0x11223344@0x40, load and fetch -> store first (mem_wr bytes 44,33,22,11 to 0x40..0x43), then load, then fetch.
- SB 0x41 @0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for 3 cycles, then one write, out_rob_st_done next cycle.
- LW in progress at byte 2, in_rob_xbp=1 -> no out_lsb_done, IDLE next cycle; a store in progress at flush completes normally.
- Async rst asserted mid-STORE -> mem_wr=0 immediately, all done pulses 0, state IDLE. With MEM_CTRL_ICACHE_EN: repeated fetch @0x100 hits in 1 cycle; SW to 0x100 then fetch misses.
